// File: rtl/hazard3_power_pkg.sv
// Shared types and constants for the Hazard3 power-sequencing controller.
package hazard3_power_pkg;

    localparam int W_PWR_STATE     = 3;
    localparam int PWR_SYNC_STAGES = 2;

    typedef enum logic [W_PWR_STATE-1:0] {
        PWR_ON     = 3'd0,
        PWR_ISO    = 3'd1,
        PWR_SW_OFF = 3'd2,
        PWR_OFF    = 3'd3,
        PWR_SW_ON  = 3'd4,
        PWR_SETTLE = 3'd5,
        PWR_UNISO  = 3'd6
    } pwr_state_t;

endpackage

// File: rtl/hazard3_sync_2ff.sv
// Flop-chain synchroniser for a single asynchronous level (pwr_good).
// The reset value is a parameter so the chain can come out of reset
// already agreeing with the expected steady-state level.
module hazard3_sync_2ff
    import hazard3_power_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [PWR_SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {PWR_SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[PWR_SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[PWR_SYNC_STAGES-1];

endmodule

// File: rtl/hazard3_power_seq.sv
// Power-sequencing controller between the Hazard3 power-control port and
// the SoC power switch, isolation cells and clock gate. Runs in the
// always-on domain.
//
// Optional build macro HAZARD3_PWR_TIMEOUT_EN: bounds the pwr_good waits in
// SW_OFF/SW_ON and raises a sticky pwr_fault when the bound expires.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  ON     | powered, ack high, clock gate follows cpu_clk_en
//  ISO    | isolation asserted, holding before switch-off
//  SW_OFF | switch off, waiting for synced pwr_good to fall
//  OFF    | powered down, ack low, waiting for pwrup_req
//  SW_ON  | switch on, waiting for synced pwr_good to rise
//  SETTLE | rail good, letting it settle before releasing isolation
//  UNISO  | isolation released, holding before ack
module hazard3_power_seq
    import hazard3_power_pkg::*;
#(
    parameter int unsigned ISO_CYCLES     = 4,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned W_CNT          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pwrup_req,
    output logic                   pwrup_ack,
    input  logic                   cpu_clk_en,
    output logic                   clk_gate_en,
    input  logic                   unblock_out,
    output logic                   unblock_in,
    output logic                   pwr_sw_en,
    input  logic                   pwr_good,
    output logic                   iso_en,
    output logic [W_PWR_STATE-1:0] pwr_state,
    output logic                   pwr_fault
);

    pwr_state_t       state_q, state_d;
    logic [W_CNT-1:0] cnt_q, cnt_d, cnt_dec;
    logic             cnt_done;
    logic             ack_q, ack_d;
    logic             sw_q, sw_d;
    logic             iso_q, iso_d;
    logic             pend_q, pend_d;
    logic             ub_phase_q, ub_phase_d;
    logic             ub_active;
    logic             pg_sync;
    logic             tmo_hit;

    hazard3_sync_2ff #(
        .RST_VAL (1'b1)
    ) u_pg_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pwr_good),
        .q_o   (pg_sync)
    );

    // Saturating decrement; "done" when the count lands on zero, so a
    // loaded value of N holds the state for max(N,1) cycles.
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - W_CNT'(1);
    assign cnt_done = (cnt_dec == '0);

`ifdef HAZARD3_PWR_TIMEOUT_EN
    logic [W_CNT-1:0] tmo_q, tmo_d;
    logic             in_wait;
    logic             fault_q;

    assign in_wait = (state_q == PWR_SW_OFF) || (state_q == PWR_SW_ON);
    assign tmo_hit = in_wait &&
                     (({1'b0, tmo_q} + (W_CNT+1)'(1)) >= (W_CNT+1)'(TIMEOUT_CYCLES));
    assign tmo_d   = (in_wait && (state_d == state_q)) ? tmo_q + W_CNT'(1) : '0;

    // Wait timer for the pwr_good phases and the sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            fault_q <= fault_q | tmo_hit;
        end
    end

    assign pwr_fault = fault_q;
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign pwr_fault  = 1'b0;
    assign unused_tmo = ^(W_CNT+1)'(TIMEOUT_CYCLES);
`endif

    // Next-state logic; control outputs are registered and change only on
    // the transitions that own them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_dec;
        ack_d   = ack_q;
        sw_d    = sw_q;
        iso_d   = iso_q;
        case (state_q)
            PWR_ON: begin
                if (!pwrup_req) begin
                    state_d = PWR_ISO;
                    iso_d   = 1'b1;
                    cnt_d   = W_CNT'(ISO_CYCLES);
                end
            end
            PWR_ISO: begin
                if (cnt_done) begin
                    state_d = PWR_SW_OFF;
                    sw_d    = 1'b0;
                end
            end
            PWR_SW_OFF: begin
                if (!pg_sync || tmo_hit) begin
                    state_d = PWR_OFF;
                end
            end
            PWR_OFF: begin
                ack_d = 1'b0;
                if (pwrup_req) begin
                    state_d = PWR_SW_ON;
                    sw_d    = 1'b1;
                end
            end
            PWR_SW_ON: begin
                if (pg_sync || tmo_hit) begin
                    state_d = PWR_SETTLE;
                    cnt_d   = W_CNT'(SETTLE_CYCLES);
                end
            end
            PWR_SETTLE: begin
                if (cnt_done) begin
                    state_d = PWR_UNISO;
                    iso_d   = 1'b0;
                    cnt_d   = W_CNT'(ISO_CYCLES);
                end
            end
            PWR_UNISO: begin
                if (cnt_done) begin
                    state_d = PWR_ON;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = PWR_ON;
            end
        endcase
    end

    // Clock gate: core request in ON, forced open while isolation is
    // toggling, closed while the rail is off or not yet settled.
    always_comb begin
        clk_gate_en = 1'b0;
        case (state_q)
            PWR_ON:              clk_gate_en = cpu_clk_en;
            PWR_ISO, PWR_UNISO:  clk_gate_en = 1'b1;
            default:             clk_gate_en = 1'b0;
        endcase
    end

    // Wake path: a pending request is presented for two ON cycles, then
    // cleared. Requests arriving while pending merge into it.
    assign ub_active  = pend_q && (state_q == PWR_ON);
    assign ub_phase_d = ub_active && !ub_phase_q;
    assign pend_d     = pend_q ? !(ub_active && ub_phase_q) : unblock_out;

    // FSM, counter, control-output and wake-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PWR_ON;
            cnt_q      <= '0;
            ack_q      <= 1'b1;
            sw_q       <= 1'b1;
            iso_q      <= 1'b0;
            pend_q     <= 1'b0;
            ub_phase_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            sw_q       <= sw_d;
            iso_q      <= iso_d;
            pend_q     <= pend_d;
            ub_phase_q <= ub_phase_d;
        end
    end

    assign pwrup_ack  = ack_q;
    assign pwr_sw_en  = sw_q;
    assign iso_en     = iso_q;
    assign unblock_in = ub_active;
    assign pwr_state  = state_q;

endmodule

// File: tb/tb_hazard3_power_seq.sv
// Directed bench for hazard3_power_seq: a per-cycle vector table for the
// full power-down/power-up sequences plus hand sequences for reset,
// clock-gate latency, the pwr_good wait bound and async reset.
module tb_hazard3_power_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwrup_req, cpu_clk_en, unblock_out, pwr_good;
    logic       pwrup_ack, clk_gate_en, unblock_in, pwr_sw_en, iso_en, pwr_fault;
    logic [2:0] pwr_state;

    int vectors = 0;
    int miscompares = 0;

    hazard3_power_seq #(
        .ISO_CYCLES     (4),
        .SETTLE_CYCLES  (16),
        .W_CNT          (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwrup_req   (pwrup_req),
        .pwrup_ack   (pwrup_ack),
        .cpu_clk_en  (cpu_clk_en),
        .clk_gate_en (clk_gate_en),
        .unblock_out (unblock_out),
        .unblock_in  (unblock_in),
        .pwr_sw_en   (pwr_sw_en),
        .pwr_good    (pwr_good),
        .iso_en      (iso_en),
        .pwr_state   (pwr_state),
        .pwr_fault   (pwr_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req, cpu, pg, ub;
        int         reps;
        logic [2:0] st;
        logic       ack, sw, iso, gate, ubin;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic req, logic cpu, logic pg, logic ub, int reps,
                                logic [2:0] st, logic ack, logic sw, logic iso,
                                logic gate, logic ubin);
        vec_t v;
        v.req = req; v.cpu = cpu; v.pg = pg; v.ub = ub; v.reps = reps;
        v.st = st; v.ack = ack; v.sw = sw; v.iso = iso; v.gate = gate; v.ubin = ubin;
        tbl.push_back(v);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Packed view {state, ack, sw, iso, gate, unblock_in, fault}.
    function automatic logic [31:0] outs();
        return {23'd0, pwr_state, pwrup_ack, pwr_sw_en, iso_en, clk_gate_en,
                unblock_in, pwr_fault};
    endfunction

    initial begin
        rst_n       = 1'b0;
        pwrup_req   = 1'b1;
        cpu_clk_en  = 1'b1;
        unblock_out = 1'b0;
        pwr_good    = 1'b1;

        // Reset values.
        step(2);
        check("reset_outputs", outs(), {23'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;
        step(2);
        check("post_reset_on", outs(), {23'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        // Clock gate follows cpu_clk_en combinationally in ON.
        cpu_clk_en = 1'b0; #1;
        check("gate_follow_lo", {31'd0, clk_gate_en}, 32'd0);
        cpu_clk_en = 1'b1; #1;
        check("gate_follow_hi", {31'd0, clk_gate_en}, 32'd1);

        //   req cpu pg ub reps  st ack sw iso gate ubin
        add(1, 0, 1, 0, 1,  0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 1,  0, 1, 1, 0, 1, 0);
        // power-down: ISO for 4 cycles, then switch off
        add(0, 1, 1, 0, 1,  1, 1, 1, 1, 1, 0);
        add(0, 1, 1, 0, 3,  1, 1, 1, 1, 1, 0);
        add(0, 1, 1, 0, 1,  2, 1, 0, 1, 0, 0);
        add(0, 1, 1, 0, 2,  2, 1, 0, 1, 0, 0);
        // pwr_good falls; two sync flops then OFF; ack falls one cycle later
        add(0, 1, 0, 0, 2,  2, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1,  3, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1,  3, 0, 0, 1, 0, 0);
        // power-up: switch on, pwr_good rises 5 cycles later
        add(1, 1, 0, 0, 1,  4, 0, 1, 1, 0, 0);
        add(1, 1, 0, 0, 4,  4, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 2,  4, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1,  5, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 15, 5, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1,  6, 0, 1, 0, 1, 0);
        add(1, 1, 1, 0, 3,  6, 0, 1, 0, 1, 0);
        add(1, 1, 1, 0, 1,  0, 1, 1, 0, 1, 0);
        // unblock in ON: two cycles of unblock_in
        add(1, 1, 1, 1, 1,  0, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 1,  0, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 1,  0, 1, 1, 0, 1, 0);
        // req re-rises during ISO: sequence still completes to OFF
        add(0, 1, 1, 0, 1,  1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 0, 3,  1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 0, 1,  2, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 2,  2, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1,  3, 1, 0, 1, 0, 0);
        // unblock pulse while OFF; req already high so power-up starts
        add(1, 1, 0, 1, 1,  4, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 2,  4, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1,  5, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 15, 5, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1,  6, 0, 1, 0, 1, 0);
        add(1, 1, 1, 0, 3,  6, 0, 1, 0, 1, 0);
        // held wake delivered on ON re-entry
        add(1, 1, 1, 0, 1,  0, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 1,  0, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 1,  0, 1, 1, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            pwrup_req   = tbl[i].req;
            cpu_clk_en  = tbl[i].cpu;
            pwr_good    = tbl[i].pg;
            unblock_out = tbl[i].ub;
            step(tbl[i].reps);
            check($sformatf("vec%0d", i), outs(),
                  {23'd0, tbl[i].st, tbl[i].ack, tbl[i].sw, tbl[i].iso,
                   tbl[i].gate, tbl[i].ubin, 1'b0});
        end

        // pwr_good stuck high during power-down.
        pwrup_req   = 1'b0;
        pwr_good    = 1'b1;
        unblock_out = 1'b0;
        step(5);
        check("stuck_enter_sw_off", {29'd0, pwr_state}, 32'd2);
        step(19);
        check("stuck_sw_off_19", {29'd0, pwr_state}, 32'd2);
        step(1);
`ifdef HAZARD3_PWR_TIMEOUT_EN
        check("timeout_exit", {28'd0, pwr_state, pwr_fault}, {28'd0, 3'd3, 1'b1});
        step(5);
        check("fault_sticky", {28'd0, pwr_state, pwr_fault}, {28'd0, 3'd3, 1'b1});
`else
        check("no_timeout_wait", {28'd0, pwr_state, pwr_fault}, {28'd0, 3'd2, 1'b0});
        step(20);
        check("no_timeout_hold", {28'd0, pwr_state, pwr_fault}, {28'd0, 3'd2, 1'b0});
`endif

        // Asynchronous reset mid-sequence, no clock edge needed.
        pwrup_req = 1'b1;
        cpu_clk_en = 1'b1;
        rst_n = 1'b0;
        #2;
        check("async_reset", outs(), {23'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        step(1);
        rst_n = 1'b1;
        step(3);
        check("after_reset_on", outs(), {23'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
